cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file and interrupt source, sitting directly downstream of the exception-decision logic in the MEM/WB boundary.
- Consumes the exception flag, type and bad address, and updates Status, Cause, EPC and BadVAddr.
- Feeds EPC, ErrorEPC and the pending-interrupt request back to exception decision.
- Serves mfc0 reads and mtc0 writes, and runs the Count/Compare timer.

Parameters:
- RESET_STATUS, 32'h0040_0000, Status value after reset (BEV=1).
- HW_INT_W, 6, number of hardware interrupt lines.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- cp0_int_i  in  HW_INT_W  external hardware interrupt lines, level-sensitive
- cp0_we_i  in  1  mtc0 write enable
- cp0_waddr_i  in  5  mtc0 register number
- cp0_wdata_i  in  32  mtc0 data
- cp0_raddr_i  in  5  mfc0 register number
- cp0_rdata_o  out  32  mfc0 data, combinational
- cp0_exc_flag_i  in  1  exception/interrupt/ERET committed this cycle
- cp0_exc_type_i  in  4  0 NoExc, 1 Intr, 2 AdEL1, 3 AdEL2, 4 AdES, 5 Ov, 6 SysC, 7 Bp, 8 RI, 9 ERET
- cp0_exc_pc_i  in  32  PC of the excepting instruction
- cp0_exc_ds_i  in  1  excepting instruction is in a delay slot
- cp0_exc_baddr_i  in  32  faulting address
- cp0_EPC_o  out  32  EPC register
- cp0_ErrorEPC_o  out  32  ErrorEPC register
- cp0_status_o  out  32  Status register
- cp0_cause_o  out  32  Cause register
- cp0_intr_o  out  1  interrupt pending and enabled

Behaviour:
- Clock and reset: single clock domain (clk); rst is synchronous and active-high.
- Reset values:
  - Status = RESET_STATUS.
  - Cause, EPC, ErrorEPC, BadVAddr, Count and Compare = 0.
  - Tick flop = 0, so cp0_intr_o = 0.
- Register map (number: fields):
  - 8: BadVAddr (read-only).
  - 9: Count.
  - 11: Compare.
  - 12: Status. Writable bits are IM[15:8], EXL[1] and IE[0]; BEV[22] is read-only; all other bits read 0.
  - 13: Cause. BD[31], TI[30] and IP[15:10] are read-only; IP[9:8] are writable; ExcCode is [6:2].
  - 14: EPC.
  - 30: ErrorEPC.
  - Any other number reads 0; writes to it are ignored.
- Read path: cp0_rdata_o is purely combinational from the current register state. A same-cycle write is not forwarded.
- Hardware IP sampling: every cycle, Cause.IP[7:2] <= {cp0_int_i[5] | Cause.TI, cp0_int_i[4:0]}. This gives a one-cycle latency from pin to IP.
- Interrupt request: cp0_intr_o = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]), computed combinationally from registers.
- Exception commit: when cp0_exc_flag_i=1 and type is 1–8, the ExcCode map is:
  - Intr → 0
  - AdEL1 and AdEL2 → 4
  - AdES → 5
  - SysC → 8
  - Bp → 9
  - RI → 10
  - Ov → 12
- Exception commit, EXL=0 case: EPC <= ds ? pc-4 : pc, and BD <= ds.
- Exception commit, EXL=1 case: EPC and BD are held.
- Exception commit, always: EXL <= 1 and ExcCode updated.
- BadVAddr <= cp0_exc_baddr_i only for types 2, 3 and 4; otherwise it is held.
- ERET: cp0_exc_flag_i=1 with type 9 sets EXL <= 0; no other register changes.
- Priority: an exception or ERET in the same cycle as an mtc0 wins on every field it touches. The mtc0 still applies to registers the exception does not touch.
- Count/Compare (timer enabled):
  - The tick flop toggles every cycle; Count increments by 1 on cycles where tick=1, wrapping 0xFFFF_FFFF→0.
  - mtc0 Count loads the value; the load overrides the increment in that cycle.
  - TI is set in the cycle after Count==Compare while Compare≠0.
  - mtc0 Compare clears TI; if the clear and a set coincide, the clear wins.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare/TI behave as above.
- Undefined:
  - Count, Compare and TI are constant 0; writes to 9/11 are ignored.
  - Reads of 9/11 return 0; IP[7] is driven only by cp0_int_i[5].
  - No tick flop is synthesized.

Test Plan:
- Reset check: assert rst 2 cycles → Status reads 0x0040_0000; Cause, EPC and BadVAddr read 0; cp0_intr_o=0.
- Non-delay-slot AdEL2: pc=0xBFC0_0100, ds=0, baddr=0x0000_0003, EXL=0 → next cycle EPC=0xBFC0_0100, BadVAddr=0x3, ExcCode=4, EXL=1, BD=0.
- Delay-slot Ov, then nested SysC, then ERET:
  - Ov with pc=0x8000_0010, ds=1 → EPC=0x8000_000C, BD=1.
  - A second SysC while EXL=1 → EPC unchanged, ExcCode=8.
  - ERET → EXL=0, EPC still 0x8000_000C.
- Hardware interrupt:
  - mtc0 Status=0x0000_0401 (IM2, IE).
  - Raise cp0_int_i[0] → IP2 set 1 cycle later and cp0_intr_o=1.
  - Set EXL via exception → cp0_intr_o=0.
- Timer (CP0_TIMER_EN):
  - mtc0 Compare=10, Count=0, Status=0x0000_8001 → TI and cp0_intr_o rise 21–22 cycles later.
  - mtc0 Compare=100 → TI=0 next cycle.
- Collision: same cycle mtc0 EPC=0x1234 and AdES exception pc=0x8000_0040 with EXL=0 → EPC=0x8000_0040 and ExcCode=5.

Source files
------------

// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile
//   Coprocessor-0 register file and interrupt source. Sits behind the
//   exception-decision logic at the MEM/WB boundary: it records committed
//   exceptions (Status.EXL, Cause.BD/ExcCode, EPC, BadVAddr), executes ERET,
//   serves mfc0 reads / mtc0 writes, samples the hardware interrupt lines and
//   raises the combined interrupt request.
//
// Build option:
//   CP0_TIMER_EN  defined   -> Count/Compare timer, tick flop and Cause.TI exist.
//                 undefined -> Count, Compare and TI read 0, writes to them are
//                              dropped, IP7 follows cp0_int_i[5] only.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   cp0_int_i         level-sensitive hardware interrupt lines
//   cp0_we_i/waddr_i/wdata_i   mtc0 write port
//   cp0_raddr_i / cp0_rdata_o  mfc0 read port (combinational, no forwarding)
//   cp0_exc_*_i       committed exception: flag, type, pc, delay-slot, bad addr
//   cp0_EPC_o, cp0_ErrorEPC_o, cp0_status_o, cp0_cause_o   register taps
//   cp0_intr_o        interrupt pending and enabled
// -----------------------------------------------------------------------------
module cp0_regfile #(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
  parameter int unsigned HW_INT_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HW_INT_W-1:0] cp0_int_i,
  input  logic                cp0_we_i,
  input  logic [4:0]          cp0_waddr_i,
  input  logic [31:0]         cp0_wdata_i,
  input  logic [4:0]          cp0_raddr_i,
  output logic [31:0]         cp0_rdata_o,
  input  logic                cp0_exc_flag_i,
  input  logic [3:0]          cp0_exc_type_i,
  input  logic [31:0]         cp0_exc_pc_i,
  input  logic                cp0_exc_ds_i,
  input  logic [31:0]         cp0_exc_baddr_i,
  output logic [31:0]         cp0_EPC_o,
  output logic [31:0]         cp0_ErrorEPC_o,
  output logic [31:0]         cp0_status_o,
  output logic [31:0]         cp0_cause_o,
  output logic                cp0_intr_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_ERROREPC = 5'd30;

  localparam logic [3:0] EXC_INTR  = 4'd1;
  localparam logic [3:0] EXC_ADEL1 = 4'd2;
  localparam logic [3:0] EXC_ADEL2 = 4'd3;
  localparam logic [3:0] EXC_ADES  = 4'd4;
  localparam logic [3:0] EXC_OV    = 4'd5;
  localparam logic [3:0] EXC_SYSC  = 4'd6;
  localparam logic [3:0] EXC_BP    = 4'd7;
  localparam logic [3:0] EXC_RI    = 4'd8;
  localparam logic [3:0] EXC_ERET  = 4'd9;

  // BEV is not writable, so it is a constant taken from the reset value.
  localparam logic STATUS_BEV = RESET_STATUS[22];

  // Normalise the interrupt pins to the six lines that map onto IP[7:2].
  logic [5:0] hw_int;
  generate
    if (HW_INT_W >= 6) begin : g_int_wide
      assign hw_int = cp0_int_i[5:0];
    end else begin : g_int_narrow
      assign hw_int = {{(6-HW_INT_W){1'b0}}, cp0_int_i};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [7:0]  status_im_q,  status_im_d;
  logic        status_exl_q, status_exl_d;
  logic        status_ie_q,  status_ie_d;
  logic        cause_bd_q,   cause_bd_d;
  logic [7:0]  cause_ip_q,   cause_ip_d;
  logic [4:0]  cause_exc_q,  cause_exc_d;
  logic [31:0] epc_q,        epc_d;
  logic [31:0] errorepc_q,   errorepc_d;
  logic [31:0] badvaddr_q,   badvaddr_d;

  // Timer views used by the rest of the block; constant 0 without the timer.
  logic        timer_ti;
  logic [31:0] count_val;
  logic [31:0] compare_val;

  // ---------------------------------------------------------------------------
  // Exception decode
  // ---------------------------------------------------------------------------
  logic       exc_take;
  logic       eret_take;
  logic       baddr_take;
  logic [4:0] exc_code;

  assign exc_take   = cp0_exc_flag_i && (cp0_exc_type_i >= EXC_INTR) &&
                      (cp0_exc_type_i <= EXC_RI);
  assign eret_take  = cp0_exc_flag_i && (cp0_exc_type_i == EXC_ERET);
  assign baddr_take = exc_take && ((cp0_exc_type_i == EXC_ADEL1) ||
                                   (cp0_exc_type_i == EXC_ADEL2) ||
                                   (cp0_exc_type_i == EXC_ADES));

  always_comb begin
    exc_code = 5'd0;
    case (cp0_exc_type_i)
      EXC_INTR:             exc_code = 5'd0;
      EXC_ADEL1, EXC_ADEL2: exc_code = 5'd4;
      EXC_ADES:             exc_code = 5'd5;
      EXC_OV:               exc_code = 5'd12;
      EXC_SYSC:             exc_code = 5'd8;
      EXC_BP:               exc_code = 5'd9;
      EXC_RI:               exc_code = 5'd10;
      default:              exc_code = 5'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // mtc0 decode
  // ---------------------------------------------------------------------------
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic wr_errorepc;

  assign wr_status   = cp0_we_i && (cp0_waddr_i == REG_STATUS);
  assign wr_cause    = cp0_we_i && (cp0_waddr_i == REG_CAUSE);
  assign wr_epc      = cp0_we_i && (cp0_waddr_i == REG_EPC);
  assign wr_errorepc = cp0_we_i && (cp0_waddr_i == REG_ERROREPC);

  // ---------------------------------------------------------------------------
  // Next-state: the mtc0 value is applied first and the exception/ERET update
  // is layered on top, so the exception wins on every field it touches while
  // the write still lands on fields it leaves alone.
  // ---------------------------------------------------------------------------
  always_comb begin
    status_im_d  = status_im_q;
    status_exl_d = status_exl_q;
    status_ie_d  = status_ie_q;
    cause_bd_d   = cause_bd_q;
    cause_ip_d   = cause_ip_q;
    cause_exc_d  = cause_exc_q;
    epc_d        = epc_q;
    errorepc_d   = errorepc_q;
    badvaddr_d   = badvaddr_q;

    if (wr_status) begin
      status_im_d  = cp0_wdata_i[15:8];
      status_exl_d = cp0_wdata_i[1];
      status_ie_d  = cp0_wdata_i[0];
    end
    if (wr_cause) begin
      cause_ip_d[1:0] = cp0_wdata_i[9:8];
    end
    if (wr_epc) begin
      epc_d = cp0_wdata_i;
    end
    if (wr_errorepc) begin
      errorepc_d = cp0_wdata_i;
    end

    // Pins reach IP one cycle later; the timer shares IP7 with pin 5.
    cause_ip_d[7:2] = {hw_int[5] | timer_ti, hw_int[4:0]};

    if (exc_take) begin
      // A nested exception (EXL already set) keeps the original return point.
      if (!status_exl_q) begin
        epc_d      = cp0_exc_ds_i ? (cp0_exc_pc_i - 32'd4) : cp0_exc_pc_i;
        cause_bd_d = cp0_exc_ds_i;
      end
      status_exl_d = 1'b1;
      cause_exc_d  = exc_code;
      if (baddr_take) begin
        badvaddr_d = cp0_exc_baddr_i;
      end
    end else if (eret_take) begin
      status_exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_im_q  <= RESET_STATUS[15:8];
      status_exl_q <= RESET_STATUS[1];
      status_ie_q  <= RESET_STATUS[0];
      cause_bd_q   <= 1'b0;
      cause_ip_q   <= 8'd0;
      cause_exc_q  <= 5'd0;
      epc_q        <= 32'd0;
      errorepc_q   <= 32'd0;
      badvaddr_q   <= 32'd0;
    end else begin
      status_im_q  <= status_im_d;
      status_exl_q <= status_exl_d;
      status_ie_q  <= status_ie_d;
      cause_bd_q   <= cause_bd_d;
      cause_ip_q   <= cause_ip_d;
      cause_exc_q  <= cause_exc_d;
      epc_q        <= epc_d;
      errorepc_q   <= errorepc_d;
      badvaddr_q   <= badvaddr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Count/Compare timer
  // ---------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
  logic        tick_q,     tick_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic        cause_ti_q, cause_ti_d;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = cp0_we_i && (cp0_waddr_i == REG_COUNT);
  assign wr_compare = cp0_we_i && (cp0_waddr_i == REG_COMPARE);

  always_comb begin
    tick_d     = ~tick_q;
    count_d    = count_q;
    compare_d  = compare_q;
    cause_ti_d = cause_ti_q;

    // Count advances at half the core rate; a load replaces the increment.
    if (wr_count) begin
      count_d = cp0_wdata_i;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end

    if (wr_compare) begin
      compare_d = cp0_wdata_i;
    end

    // Compare==0 disables the match; a Compare write acknowledges TI and
    // beats a match landing in the same cycle.
    if (wr_compare) begin
      cause_ti_d = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      cause_ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q     <= 1'b0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      cause_ti_q <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      cause_ti_q <= cause_ti_d;
    end
  end

  assign timer_ti    = cause_ti_q;
  assign count_val   = count_q;
  assign compare_val = compare_q;
`else
  assign timer_ti    = 1'b0;
  assign count_val   = 32'd0;
  assign compare_val = 32'd0;
`endif

  // ---------------------------------------------------------------------------
  // Register views, read mux and interrupt request
  // ---------------------------------------------------------------------------
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  assign status_rd = {9'd0, STATUS_BEV, 6'd0, status_im_q, 6'd0,
                      status_exl_q, status_ie_q};
  assign cause_rd  = {cause_bd_q, timer_ti, 14'd0, cause_ip_q, 1'b0,
                      cause_exc_q, 2'b00};

  always_comb begin
    cp0_rdata_o = 32'd0;
    case (cp0_raddr_i)
      REG_BADVADDR: cp0_rdata_o = badvaddr_q;
      REG_COUNT:    cp0_rdata_o = count_val;
      REG_COMPARE:  cp0_rdata_o = compare_val;
      REG_STATUS:   cp0_rdata_o = status_rd;
      REG_CAUSE:    cp0_rdata_o = cause_rd;
      REG_EPC:      cp0_rdata_o = epc_q;
      REG_ERROREPC: cp0_rdata_o = errorepc_q;
      default:      cp0_rdata_o = 32'd0;
    endcase
  end

  assign cp0_EPC_o      = epc_q;
  assign cp0_ErrorEPC_o = errorepc_q;
  assign cp0_status_o   = status_rd;
  assign cp0_cause_o    = cause_rd;
  assign cp0_intr_o     = status_ie_q & ~status_exl_q &
                          (|(cause_ip_q & status_im_q));

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

  logic        clk;
  logic        rst;
  logic [5:0]  cp0_int_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic [4:0]  cp0_raddr_i;
  logic [31:0] cp0_rdata_o;
  logic        cp0_exc_flag_i;
  logic [3:0]  cp0_exc_type_i;
  logic [31:0] cp0_exc_pc_i;
  logic        cp0_exc_ds_i;
  logic [31:0] cp0_exc_baddr_i;
  logic [31:0] cp0_EPC_o;
  logic [31:0] cp0_ErrorEPC_o;
  logic [31:0] cp0_status_o;
  logic [31:0] cp0_cause_o;
  logic        cp0_intr_o;

  cp0_regfile #(
    .RESET_STATUS (32'h0040_0000),
    .HW_INT_W     (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cp0_int_i       (cp0_int_i),
    .cp0_we_i        (cp0_we_i),
    .cp0_waddr_i     (cp0_waddr_i),
    .cp0_wdata_i     (cp0_wdata_i),
    .cp0_raddr_i     (cp0_raddr_i),
    .cp0_rdata_o     (cp0_rdata_o),
    .cp0_exc_flag_i  (cp0_exc_flag_i),
    .cp0_exc_type_i  (cp0_exc_type_i),
    .cp0_exc_pc_i    (cp0_exc_pc_i),
    .cp0_exc_ds_i    (cp0_exc_ds_i),
    .cp0_exc_baddr_i (cp0_exc_baddr_i),
    .cp0_EPC_o       (cp0_EPC_o),
    .cp0_ErrorEPC_o  (cp0_ErrorEPC_o),
    .cp0_status_o    (cp0_status_o),
    .cp0_cause_o     (cp0_cause_o),
    .cp0_intr_o      (cp0_intr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: stimulus pushes expectations, monitor pops on chk_req.
  localparam int K_RDATA = 0, K_INTR = 1, K_EPC = 2, K_STATUS = 3,
                 K_CAUSE = 4, K_ERROREPC = 5;

  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  logic        chk_req;
  int          checks;
  int          errors;

  always @(negedge clk) begin
    if (chk_req) begin
      logic [31:0] act;
      logic [31:0] expv;
      int          kind;
      string       nm;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got empty queue, required an entry");
      end else begin
        expv = exp_q.pop_front();
        kind = kind_q.pop_front();
        nm   = name_q.pop_front();
        case (kind)
          K_RDATA:    act = cp0_rdata_o;
          K_INTR:     act = {31'd0, cp0_intr_o};
          K_EPC:      act = cp0_EPC_o;
          K_STATUS:   act = cp0_status_o;
          K_CAUSE:    act = cp0_cause_o;
          K_ERROREPC: act = cp0_ErrorEPC_o;
          default:    act = 32'hxxxx_xxxx;
        endcase
        if (act !== expv)
          begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, expv);
          end
      end
    end
  end

  task automatic chk(input int kind, input logic [4:0] addr,
                     input logic [31:0] expv, input string nm);
    exp_q.push_back(expv);
    kind_q.push_back(kind);
    name_q.push_back(nm);
    cp0_raddr_i = addr;
    chk_req     = 1'b1;
    @(posedge clk); #1;
    chk_req     = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] expv,
                    input string nm);
    chk(K_RDATA, addr, expv, nm);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    cp0_we_i    = 1'b1;
    cp0_waddr_i = addr;
    cp0_wdata_i = data;
    @(posedge clk); #1;
    cp0_we_i    = 1'b0;
  endtask

  task automatic exc(input logic [3:0] typ, input logic [31:0] pc,
                     input logic ds, input logic [31:0] baddr);
    cp0_exc_flag_i  = 1'b1;
    cp0_exc_type_i  = typ;
    cp0_exc_pc_i    = pc;
    cp0_exc_ds_i    = ds;
    cp0_exc_baddr_i = baddr;
    @(posedge clk); #1;
    cp0_exc_flag_i  = 1'b0;
    cp0_exc_type_i  = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    checks          = 0;
    errors          = 0;
    chk_req         = 1'b0;
    rst             = 1'b1;
    cp0_int_i       = 6'd0;
    cp0_we_i        = 1'b0;
    cp0_waddr_i     = 5'd0;
    cp0_wdata_i     = 32'd0;
    cp0_raddr_i     = 5'd0;
    cp0_exc_flag_i  = 1'b0;
    cp0_exc_type_i  = 4'd0;
    cp0_exc_pc_i    = 32'd0;
    cp0_exc_ds_i    = 1'b0;
    cp0_exc_baddr_i = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    rd(5'd12, 32'h0040_0000, "reset_status");
    rd(5'd13, 32'h0000_0000, "reset_cause");
    rd(5'd14, 32'h0000_0000, "reset_epc");
    rd(5'd8,  32'h0000_0000, "reset_badvaddr");
    rd(5'd30, 32'h0000_0000, "reset_errorepc");
    chk(K_INTR, 5'd0, 32'd0, "reset_intr");
    chk(K_STATUS, 5'd0, 32'h0040_0000, "reset_status_port");

    // Non-delay-slot AdEL2
    exc(4'd3, 32'hBFC0_0100, 1'b0, 32'h0000_0003);
    rd(5'd14, 32'hBFC0_0100, "adel2_epc");
    rd(5'd8,  32'h0000_0003, "adel2_badvaddr");
    rd(5'd13, 32'h0000_0010, "adel2_cause");
    rd(5'd12, 32'h0040_0002, "adel2_status");
    exc(4'd9, 32'h0, 1'b0, 32'h0);
    rd(5'd12, 32'h0040_0000, "eret1_status");

    // Delay-slot Ov, nested SysC, ERET
    exc(4'd5, 32'h8000_0010, 1'b1, 32'h0000_DEAD);
    rd(5'd14, 32'h8000_000C, "ov_ds_epc");
    rd(5'd13, 32'h8000_0030, "ov_ds_cause");
    rd(5'd8,  32'h0000_0003, "ov_badvaddr_held");
    exc(4'd6, 32'h8000_0100, 1'b0, 32'h0000_0055);
    rd(5'd14, 32'h8000_000C, "nested_epc_held");
    rd(5'd13, 32'h8000_0020, "nested_cause");
    exc(4'd9, 32'h0, 1'b0, 32'h0);
    rd(5'd12, 32'h0040_0000, "eret2_status");
    chk(K_EPC, 5'd0, 32'h8000_000C, "eret2_epc_port");

    // Hardware interrupt
    wr(5'd12, 32'h0000_0401);
    rd(5'd12, 32'h0040_0401, "im2_status");
    cp0_int_i = 6'b00_0001;
    chk(K_INTR, 5'd0, 32'd0, "hwint_latency");
    chk(K_INTR, 5'd0, 32'd1, "hwint_intr");
    rd(5'd13, 32'h8000_0420, "hwint_cause");
    exc(4'd1, 32'h8000_0200, 1'b0, 32'h0);
    chk(K_INTR, 5'd0, 32'd0, "exl_masks_intr");
    chk(K_CAUSE, 5'd0, 32'h0000_0400, "intr_exc_cause");
    chk(K_EPC, 5'd0, 32'h8000_0200, "intr_exc_epc");
    rd(5'd12, 32'h0040_0403, "intr_exc_status");
    cp0_int_i = 6'd0;
    exc(4'd9, 32'h0, 1'b0, 32'h0);
    rd(5'd13, 32'h0000_0000, "hwint_dropped_cause");
    chk(K_INTR, 5'd0, 32'd0, "hwint_dropped_intr");

    // Software IP, write masks, ignored registers
    wr(5'd13, 32'hFFFF_FFFF & 32'h0000_0300);
    rd(5'd13, 32'h0000_0300, "sw_ip_cause");
    chk(K_INTR, 5'd0, 32'd0, "sw_ip_masked");
    wr(5'd12, 32'h0000_0101);
    chk(K_INTR, 5'd0, 32'd1, "sw_ip_intr");
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0000_0300, "cause_ro_bits");
    wr(5'd13, 32'h0);
    chk(K_INTR, 5'd0, 32'd0, "sw_ip_cleared");
    wr(5'd8, 32'h0000_FFFF);
    rd(5'd8, 32'h0000_0003, "badvaddr_ro");
    wr(5'd5, 32'h1234_5678);
    rd(5'd5, 32'h0000_0000, "unmapped_read");
    wr(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, 32'h0040_FF03, "status_write_mask");
    wr(5'd12, 32'h0);
    rd(5'd12, 32'h0040_0000, "status_cleared");

    // Collision: mtc0 EPC with AdES exception
    cp0_we_i    = 1'b1;
    cp0_waddr_i = 5'd14;
    cp0_wdata_i = 32'h0000_1234;
    exc(4'd4, 32'h8000_0040, 1'b0, 32'h8000_0041);
    cp0_we_i    = 1'b0;
    rd(5'd14, 32'h8000_0040, "collide_epc");
    rd(5'd13, 32'h0000_0014, "collide_cause");
    rd(5'd8,  32'h8000_0041, "collide_badvaddr");
    // ERET beats the EXL bit of a same-cycle Status write, IM/IE still land
    cp0_we_i    = 1'b1;
    cp0_waddr_i = 5'd12;
    cp0_wdata_i = 32'h0000_0403;
    exc(4'd9, 32'h0, 1'b0, 32'h0);
    cp0_we_i    = 1'b0;
    rd(5'd12, 32'h0040_0401, "eret_vs_mtc0_status");
    wr(5'd30, 32'hCAFE_BABE);
    rd(5'd30, 32'hCAFE_BABE, "errorepc_rd");
    chk(K_ERROREPC, 5'd0, 32'hCAFE_BABE, "errorepc_port");

`ifdef CP0_TIMER_EN
    wr(5'd9, 32'd0);
    wr(5'd11, 32'd10);
    wr(5'd9, 32'd0);
    wr(5'd12, 32'h0000_8001);
    n = 1;
    while (n <= 40 && !cp0_intr_o) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n < 21 || n > 22) begin
      errors++;
      $display("FAIL timer_latency: got %0d cycles required 21..22", n);
    end
    rd(5'd13, 32'h4000_8014, "timer_ti_cause");
    rd(5'd11, 32'd10, "timer_compare");
    wr(5'd11, 32'd100);
    rd(5'd13, 32'h0000_8014, "compare_clears_ti");
    rd(5'd13, 32'h0000_0014, "ip7_follows_ti");
    chk(K_INTR, 5'd0, 32'd0, "timer_intr_cleared");
    wr(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, 32'hFFFF_FFFF, "count_load");
    @(posedge clk); #1;
    rd(5'd9, 32'h0000_0000, "count_wrap");
`else
    n = 0;
    wr(5'd9, 32'd5);
    wr(5'd11, 32'd7);
    rd(5'd9, 32'd0, "count_absent");
    rd(5'd11, 32'd0, "compare_absent");
`endif

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
